// File: rtl/video_timing_gen.sv
// video_timing_gen
// Free-running raster timing generator on the pixel clock. It produces sync,
// data-enable and active-area coordinates from compile-time timing parameters.
// Each line and each frame runs in the order sync, back porch, active, front porch.
//
// Ports:
//   clk_pixel    in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run request (level)
//   hs, vs       out  syncs, asserted level HS_POL / VS_POL
//   de           out  high during active pixels
//   x, y         out  active column / line (x = 0 outside de, y holds)
//   frame_start  out  one-cycle pulse on the first clock of a frame
//   line_start   out  one-cycle pulse on the first clock of every line
//   rgb          out  colour-bar pattern, only with VIDEO_TIMING_GEN_PATTERN_EN
//
// Optional feature macro: VIDEO_TIMING_GEN_PATTERN_EN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | counters held at 0, syncs deasserted, de low
// RUN   | counting, frames repeat while en = 1
// STOP  | en dropped, finish the current frame then go IDLE
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        en,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        frame_start,
    output logic        line_start
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    output logic [23:0] rgb
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    generate
        if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_total_check
            $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds 65535");
        end
    endgenerate

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
    localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
    localparam logic [15:0] H_DE_BEG   = 16'(H_SYNC + H_BP);
    localparam logic [15:0] V_DE_BEG   = 16'(V_SYNC + V_BP);
    localparam logic [15:0] H_DE_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] V_DE_END   = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic        HS_ON      = 1'(HS_POL);
    localparam logic        VS_ON      = 1'(VS_POL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [15:0] x_nxt;
    logic        active, h_wrap, frame_end, de_nxt;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        active    = (state != S_IDLE);
        h_wrap    = (h_cnt == H_LAST);
        frame_end = h_wrap && (v_cnt == V_LAST);
        h_nxt     = '0;
        v_nxt     = '0;

        // en has priority in STOP, so a re-request on the last clock of the
        // frame carries straight on into the next frame.
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!en) state_nxt = S_STOP;
            S_STOP: begin
                if (en)             state_nxt = S_RUN;
                else if (frame_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (active) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
            end else begin
                h_nxt = h_cnt + 16'd1;
                v_nxt = v_cnt;
            end
        end

        de_nxt = active
               && (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END)
               && (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
        x_nxt  = de_nxt ? (h_cnt - H_DE_BEG) : 16'd0;
    end

    // Every output is registered from the current counter value, so all of
    // them lag the counters by exactly one clock and stay mutually aligned.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hs          <= (active && (h_cnt < H_SYNC_END)) ? HS_ON : ~HS_ON;
            vs          <= (active && (v_cnt < V_SYNC_END)) ? VS_ON : ~VS_ON;
            de          <= de_nxt;
            x           <= x_nxt;
            line_start  <= active && (h_cnt == 16'd0);
            frame_start <= active && (h_cnt == 16'd0) && (v_cnt == 16'd0);
            if (de_nxt)
                y <= v_cnt - V_DE_BEG;
            else if (active && (h_cnt == 16'd0) && (v_cnt == 16'd0))
                y <= '0;
        end
    end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    // Eight bars of H_ACTIVE/8 pixels; bar indices past 7 fold into the last
    // bar so it absorbs the remainder. Bar order white..black maps to
    // r = ~idx[1], g = ~idx[2], b = ~idx[0].
    localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [15:0] BAR_W16 = 16'(BAR_W);

    logic [15:0] bar_raw;
    logic [2:0]  bar_idx;
    logic [23:0] rgb_nxt;

    always_comb begin
        bar_raw = x_nxt / BAR_W16;
        bar_idx = (bar_raw > 16'd7) ? 3'd7 : bar_raw[2:0];
        rgb_nxt = de_nxt ? {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}} : 24'd0;
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else        rgb <= rgb_nxt;
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_s;
    logic en_d, en_s, en_p;

    logic        hs_d, vs_d, de_d, fs_d, ls_d;
    logic [15:0] x_d, y_d;
    logic        hs_s, vs_s, de_s, fs_s, ls_s;
    logic [15:0] x_s, y_s;
    logic        hs_p, vs_p, de_p, fs_p, ls_p;
    logic [15:0] x_p, y_p;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [23:0] rgb_d, rgb_s, rgb_p;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    video_timing_gen dut_d (
        .clk_pixel(clk), .rst_n(rst_n), .en(en_d),
        .hs(hs_d), .vs(vs_d), .de(de_d), .x(x_d), .y(y_d),
        .frame_start(fs_d), .line_start(ls_d)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        , .rgb(rgb_d)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk_pixel(clk), .rst_n(rst_s), .en(en_s),
        .hs(hs_s), .vs(vs_s), .de(de_s), .x(x_s), .y(y_s),
        .frame_start(fs_s), .line_start(ls_s)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        , .rgb(rgb_s)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0)
    ) dut_p (
        .clk_pixel(clk), .rst_n(rst_n), .en(en_p),
        .hs(hs_p), .vs(vs_p), .de(de_p), .x(x_p), .y(y_p),
        .frame_start(fs_p), .line_start(ls_p)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        , .rgb(rgb_p)
`endif
    );

    // Expected outputs of the small-parameter raster (line 25, frame 13 lines).
    logic        e_hs, e_vs, e_de, e_fs, e_ls;
    logic [15:0] e_x, e_y;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_small(input int t);
        int h, v;
        h    = t % 25;
        v    = (t / 25) % 13;
        e_hs = (h < 3);
        e_vs = (v < 2);
        e_de = (h >= 7) && (h <= 22) && (v >= 4) && (v <= 11);
        e_x  = e_de ? 16'(h - 7) : 16'd0;
        e_fs = (h == 0) && (v == 0);
        e_ls = (h == 0);
        if (e_de)      e_y = 16'(v - 4);
        else if (e_fs) e_y = 16'd0;
    endtask

    function automatic logic [23:0] bar_color(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Steps dut_s through frame clocks t0..t1, checking each; en_s is dropped
    // after the check at drop_at and raised again after the check at raise_at.
    task automatic run_small(input int t0, input int t1, input int drop_at,
                             input int raise_at, input string tag);
        logic [36:0] act, exp;
        for (int t = t0; t <= t1; t++) begin
            model_small(t);
            act = {hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s};
            exp = {e_hs, e_vs, e_de, e_fs, e_ls, e_x, e_y};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s t=%0d {hs,vs,de,fs,ls,x,y} got %h want %h", tag, t, act, exp);
            end
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
            n_checks++;
            if (rgb_s !== (e_de ? bar_color(int'(e_x) / 2) : 24'h0)) begin
                n_fail++;
                $display("FAIL %s_rgb t=%0d x=%0d got %h want %h", tag, t, e_x, rgb_s,
                         e_de ? bar_color(int'(e_x) / 2) : 24'h0);
            end
`endif
            if (t == drop_at)  en_s = 1'b0;
            if (t == raise_at) en_s = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset;
        int pulses;
        rst_n = 1'b0; rst_s = 1'b0;
        en_d = 1'b0; en_s = 1'b0; en_p = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({hs_d, vs_d, de_d, fs_d, ls_d, x_d, y_d} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_default got %h want 0", {hs_d, vs_d, de_d, fs_d, ls_d, x_d, y_d});
        end
        n_checks++;
        if ({hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_small got %h want 0", {hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s});
        end
        n_checks++;
        if ({hs_p, vs_p, de_p} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_inv_pol {hs,vs,de} got %b want 110", {hs_p, vs_p, de_p});
        end
        rst_n = 1'b1; rst_s = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            pulses += int'(fs_d) + int'(ls_d) + int'(de_d) + int'(hs_d) + int'(vs_d);
            pulses += int'(fs_s) + int'(ls_s) + int'(de_s);
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL idle_no_pulses got %0d active samples want 0", pulses);
        end
    endtask

    task automatic test_default;
        int h, v, hs_cnt, vs_cnt, ls_cnt;
        logic [4:0] exp;
        hs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
        en_d = 1'b1;
        tick();
        tick();
        for (int t = 0; t < 11010; t++) begin
            h   = t % 2200;
            v   = t / 2200;
            exp = {h < 44, v < 5, 1'b0, t == 0, h == 0};
            n_checks++;
            if ({hs_d, vs_d, de_d, fs_d, ls_d} !== exp) begin
                n_fail++;
                $display("FAIL default_raster t=%0d {hs,vs,de,fs,ls} got %b want %b", t,
                         {hs_d, vs_d, de_d, fs_d, ls_d}, exp);
            end
            if (t < 2200) hs_cnt += int'(hs_d);
            vs_cnt += int'(vs_d);
            ls_cnt += int'(ls_d);
            tick();
        end
        n_checks++;
        if (hs_cnt !== 44) begin
            n_fail++;
            $display("FAIL default_hs_width got %0d want 44", hs_cnt);
        end
        n_checks++;
        if (vs_cnt !== 11000) begin
            n_fail++;
            $display("FAIL default_vs_width got %0d want 11000", vs_cnt);
        end
        n_checks++;
        if (ls_cnt !== 6) begin
            n_fail++;
            $display("FAIL default_line_count got %0d want 6", ls_cnt);
        end
        en_d = 1'b0;
    endtask

    task automatic test_polarity;
        int hs_low, vs_low;
        hs_low = 0; vs_low = 0;
        e_y  = 16'd0;
        en_p = 1'b1;
        tick();
        tick();
        for (int t = 0; t < 325; t++) begin
            model_small(t);
            n_checks++;
            if ({hs_p, vs_p, de_p} !== {~e_hs, ~e_vs, e_de}) begin
                n_fail++;
                $display("FAIL inv_pol t=%0d {hs,vs,de} got %b want %b", t,
                         {hs_p, vs_p, de_p}, {~e_hs, ~e_vs, e_de});
            end
            if (t < 25) hs_low += int'(!hs_p);
            vs_low += int'(!vs_p);
            tick();
        end
        n_checks++;
        if (hs_low !== 3) begin
            n_fail++;
            $display("FAIL inv_pol_hs_width got %0d want 3", hs_low);
        end
        n_checks++;
        if (vs_low !== 50) begin
            n_fail++;
            $display("FAIL inv_pol_vs_width got %0d want 50", vs_low);
        end
        en_p = 1'b0;
        for (int i = 0; i < 340; i++) tick();
        n_checks++;
        if ({hs_p, vs_p, de_p, ls_p} !== 4'b1100) begin
            n_fail++;
            $display("FAIL inv_pol_idle {hs,vs,de,ls} got %b want 1100", {hs_p, vs_p, de_p, ls_p});
        end
    endtask

    task automatic test_small_run;
        e_y  = 16'd0;
        en_s = 1'b1;
        tick();
        tick();
        run_small(0, 649, -1, -1, "small_run");
    endtask

    task automatic test_stop;
        // En dropped at frame clock 100 of the third frame; frame ends at 974.
        run_small(650, 974, 750, -1, "stop_finish");
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s} !== {5'b0, 16'd0, 16'd7}) begin
                n_fail++;
                $display("FAIL stop_idle i=%0d {hs,vs,de,fs,ls,x,y} got %h want %h", i,
                         {hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s}, {5'b0, 16'd0, 16'd7});
            end
            tick();
        end
    endtask

    task automatic test_resume;
        en_s = 1'b1;
        tick();
        tick();
        // Re-request lands on the final clock of the frame while in STOP.
        run_small(0, 399, 150, 323, "resume_last_clk");
        // Re-request in the middle of STOP.
        run_small(400, 1110, 400, 500, "resume_mid");
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #2 rst_s = 1'b0;
        #1;
        n_checks++;
        if ({hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid got %h want 0", {hs_s, vs_s, de_s, fs_s, ls_s, x_s, y_s});
        end
        @(negedge clk);
        rst_s = 1'b1;
        e_y   = 16'd0;
        tick();
        tick();
        run_small(0, 400, -1, -1, "reset_restart");
    endtask

    initial begin
        test_reset();
        test_default();
        test_polarity();
        test_small_run();
        test_stop();
        test_resume();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
